// File: rtl/rx_pkg.sv
// rx_pkg: shared FSM state encoding and default maximum packet length for rx_desc_scheduler
package rx_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, GAP} state_t;
  localparam int MAX_LEN_DEF = 4096;
endpackage

// File: rtl/rx_desc_scheduler_if.sv
// rx_desc_scheduler_if: descriptor channel to the packet reader (addr/len/valid out, ack back); master=scheduler, slave=reader
interface rx_desc_scheduler_if;
  logic [31:0] addr;
  logic [15:0] len;
  logic        valid;
  logic        ack;
  modport master(output addr, len, valid, input ack);
  modport slave(input addr, len, valid, output ack);
endinterface

// File: rtl/rx_desc_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin pick over req starting at ptr; ports req/ptr in, one-hot grant, grant index idx and any out
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  int j;
  always_comb begin
    grant = '0;
    idx = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/rx_desc_scheduler.sv
// rx_desc_scheduler: per-requester descriptor slots, round-robin issue to a packet reader, length check, completions; ports per requester addr/len/valid/ready/enable, pkt_* reader channel, cpl_* completion, busy/count status
module rx_desc_scheduler
  import rx_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic                     axi_clk,
  input  logic                     axi_aresetn,
  input  logic [N_REQ*32-1:0]      req_addr_i,
  input  logic [N_REQ*16-1:0]      req_len_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ-1:0]         req_enable_i,
  output logic [31:0]              pkt_addr_o,
  output logic [15:0]              pkt_len_o,
  output logic                     pkt_addr_v_o,
  input  logic                     pkt_ack_i,
  output logic                     cpl_valid_o,
  output logic [$clog2(N_REQ)-1:0] cpl_id_o,
  output logic [15:0]              cpl_len_o,
  output logic                     cpl_err_o,
  output logic                     busy_o,
  output logic [31:0]              pkt_count_o
);
  localparam int IW = $clog2(N_REQ);
  state_t state, state_n;
  logic [N_REQ-1:0] full, clr, gnt;
  logic [31:0] slot_addr [N_REQ];
  logic [15:0] slot_len [N_REQ];
  logic [IW-1:0] rr_ptr, gidx, cur_id, gidx_nxt, cur_nxt;
  logic [15:0] glen;
  logic any, len_ok, issue, reject, done;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req(full & req_enable_i),
    .ptr(rr_ptr),
    .grant(gnt),
    .idx(gidx),
    .any(any)
  );
  always_comb begin
    glen = slot_len[gidx];
    len_ok = (glen != 16'd0) && (int'(glen) <= MAX_LEN);
    issue = (state == IDLE) && any && len_ok;
    reject = (state == IDLE) && any && !len_ok;
    done = (state == WAIT_ACK) && pkt_ack_i;
    state_n = issue ? WAIT_ACK : done ? GAP : (state == GAP) ? IDLE : state;
    clr = reject ? gnt : done ? N_REQ'(1) << cur_id : '0;
    gidx_nxt = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
    cur_nxt = (cur_id == IW'(N_REQ - 1)) ? '0 : cur_id + 1'b1;
  end
  always_ff @(posedge axi_clk or negedge axi_aresetn)
    if (!axi_aresetn) state <= IDLE;
    else state <= state_n;
  // A full slot has ready low, so capture and clear never hit the same slot together.
  always_ff @(posedge axi_clk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      full <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        slot_addr[i] <= '0;
        slot_len[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (clr[i]) full[i] <= 1'b0;
        else if (req_valid_i[i] && !full[i]) begin
          full[i] <= 1'b1;
          slot_addr[i] <= req_addr_i[32*i +: 32];
          slot_len[i] <= req_len_i[16*i +: 16];
        end
      end
    end
  always_ff @(posedge axi_clk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      rr_ptr <= '0;
      cur_id <= '0;
      pkt_addr_o <= '0;
      pkt_len_o <= '0;
      pkt_addr_v_o <= 1'b0;
      pkt_count_o <= '0;
      cpl_valid_o <= 1'b0;
      cpl_id_o <= '0;
      cpl_len_o <= '0;
      cpl_err_o <= 1'b0;
    end else begin
      cpl_valid_o <= reject | done;
      cpl_err_o <= reject;
      if (issue) begin
        pkt_addr_o <= slot_addr[gidx];
        pkt_len_o <= glen;
        pkt_addr_v_o <= 1'b1;
        cur_id <= gidx;
      end
      if (reject) begin
        cpl_id_o <= gidx;
        cpl_len_o <= glen;
        rr_ptr <= gidx_nxt;
      end
      if (done) begin
        pkt_addr_v_o <= 1'b0;
        pkt_count_o <= pkt_count_o + 32'd1;
        cpl_id_o <= cur_id;
        cpl_len_o <= pkt_len_o;
        rr_ptr <= cur_nxt;
      end
    end
  assign req_ready_o = ~full;
  assign busy_o = state != IDLE;
endmodule

// File: tb/tb_rx_desc_scheduler.sv
// tb_rx_desc_scheduler: directed stimulus with expected packets/completions queued and checked by a separate monitor
module tb_rx_desc_scheduler;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  rx_desc_scheduler_if pkt();
  logic [127:0] addr_v;
  logic [63:0] len_v;
  logic [3:0] valid, ready, en;
  logic cpl_valid, cpl_err, busy;
  logic [1:0] cpl_id;
  logic [15:0] cpl_len;
  logic [31:0] count;
  rx_desc_scheduler dut (
    .axi_clk(clk),
    .axi_aresetn(rstn),
    .req_addr_i(addr_v),
    .req_len_i(len_v),
    .req_valid_i(valid),
    .req_ready_o(ready),
    .req_enable_i(en),
    .pkt_addr_o(pkt.addr),
    .pkt_len_o(pkt.len),
    .pkt_addr_v_o(pkt.valid),
    .pkt_ack_i(pkt.ack),
    .cpl_valid_o(cpl_valid),
    .cpl_id_o(cpl_id),
    .cpl_len_o(cpl_len),
    .cpl_err_o(cpl_err),
    .busy_o(busy),
    .pkt_count_o(count)
  );
  typedef struct {logic [31:0] a; logic [15:0] l;} pkt_t;
  typedef struct {logic [1:0] id; logic [15:0] l; logic e;} cpl_t;
  pkt_t exp_pkt[$];
  cpl_t exp_cpl[$];
  int total = 0, bad = 0, cyc = 0;
  int rise_cyc = 0, last_ack = -1, rd_cnt = 0, ack_dly = 3;
  logic hold = 1'b0, gap_chk = 1'b0, prev_v = 1'b0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic fail(string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    pkt.ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pkt.ack = 1'b0;
      if (pkt.valid && !hold) begin
        rd_cnt++;
        if (rd_cnt >= ack_dly) begin
          pkt.ack = 1'b1;
          rd_cnt = 0;
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (pkt.valid && !prev_v) begin
      rise_cyc = cyc;
      if (exp_pkt.size() == 0) fail("unexpected_pkt");
      else begin
        pkt_t p;
        p = exp_pkt.pop_front();
        chk("pkt_addr_len", {pkt.addr, pkt.len}, {p.a, p.l});
      end
      if (gap_chk && last_ack >= 0) chk("ack_to_issue_gap", cyc - last_ack, 3);
    end
    if (!gap_chk) last_ack = -1;
    else if (pkt.valid && pkt.ack) last_ack = cyc;
    prev_v = pkt.valid;
    if (cpl_valid) begin
      if (exp_cpl.size() == 0) fail("unexpected_cpl");
      else begin
        cpl_t c;
        c = exp_cpl.pop_front();
        chk("cpl_id_len_err", {cpl_id, cpl_len, cpl_err}, {c.id, c.l, c.e});
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
    valid = '0;
  endtask
  task automatic put(int id, logic [31:0] a, logic [15:0] l);
    addr_v[32*id +: 32] = a;
    len_v[16*id +: 16] = l;
    valid[id] = 1'b1;
  endtask
  task automatic expect_pkt(int id, logic [31:0] a, logic [15:0] l);
    exp_pkt.push_back('{a: a, l: l});
    exp_cpl.push_back('{id: 2'(id), l: l, e: 1'b0});
  endtask
  task automatic do_reset;
    rstn = 1'b0;
    #1;
    chk("rst_ready", 64'(ready), 64'hF);
    chk("rst_flags", {pkt.valid, cpl_valid, cpl_err, busy}, 0);
    chk("rst_count", count, 0);
    chk("rst_pkt", {pkt.addr, pkt.len}, 0);
    chk("rst_cpl", {cpl_id, cpl_len}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask
  task automatic drain(int limit);
    int n = 0;
    while ((exp_pkt.size() != 0 || exp_cpl.size() != 0 || busy || ready != 4'hF) && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) fail("drain_timeout");
  endtask
  task automatic wait_v(int limit);
    int n = 0;
    while (!pkt.valid && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) fail("issue_timeout");
  endtask
  initial begin
    int drv, n, diffs;
    logic [48:0] snap;
    valid = '0;
    en = 4'hF;
    addr_v = '0;
    len_v = '0;
    do_reset();
    tick();
    expect_pkt(2, 32'h1000, 16'd64);
    drv = cyc;
    put(2, 32'h1000, 16'd64);
    tick();
    drain(200);
    chk("single_latency", rise_cyc - drv, 2);
    chk("single_count", count, 1);
    do_reset();
    tick();
    ack_dly = 2;
    gap_chk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_pkt(i, 32'h2000 + 32'(i) * 32'h100, 16'(16 * (i + 1)));
      put(i, 32'h2000 + 32'(i) * 32'h100, 16'(16 * (i + 1)));
    end
    tick();
    drain(300);
    gap_chk = 1'b0;
    chk("rr_count", count, 4);
    exp_cpl.push_back('{id: 2'd1, l: 16'd0, e: 1'b1});
    exp_cpl.push_back('{id: 2'd3, l: 16'd4097, e: 1'b1});
    put(1, 32'h3000, 16'd0);
    put(3, 32'h3100, 16'd4097);
    tick();
    drain(100);
    chk("err_count", count, 4);
    expect_pkt(0, 32'h3200, 16'd4096);
    put(0, 32'h3200, 16'd4096);
    tick();
    drain(100);
    chk("maxlen_count", count, 5);
    en = 4'b1011;
    expect_pkt(1, 32'h4100, 16'd11);
    expect_pkt(3, 32'h4300, 16'd33);
    expect_pkt(0, 32'h4000, 16'd1);
    expect_pkt(2, 32'h4200, 16'd22);
    put(0, 32'h4000, 16'd1);
    put(1, 32'h4100, 16'd11);
    put(2, 32'h4200, 16'd22);
    put(3, 32'h4300, 16'd33);
    tick();
    n = 0;
    while ((exp_pkt.size() != 1 || busy) && n < 300) begin
      tick();
      n++;
    end
    repeat (10) tick();
    chk("disabled_held", 64'(ready), 64'hB);
    chk("disabled_left", exp_pkt.size(), 1);
    en = 4'hF;
    drain(100);
    chk("enable_count", count, 9);
    hold = 1'b1;
    expect_pkt(1, 32'h5000, 16'd100);
    put(1, 32'h5000, 16'd100);
    tick();
    wait_v(20);
    snap = {pkt.addr, pkt.len, pkt.valid};
    diffs = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if ({pkt.addr, pkt.len, pkt.valid} !== snap || cpl_valid) diffs++;
    end
    chk("withheld_stable", diffs, 0);
    hold = 1'b0;
    drain(100);
    chk("withheld_count", count, 10);
    #1 pkt.ack = 1'b1;
    tick();
    repeat (3) tick();
    chk("stray_ack", {busy, count}, {1'b0, 32'd10});
    hold = 1'b1;
    exp_pkt.push_back('{a: 32'h6000, l: 16'd32});
    put(2, 32'h6000, 16'd32);
    tick();
    wait_v(20);
    tick();
    do_reset();
    repeat (10) tick();
    hold = 1'b0;
    chk("final_pkt_q", exp_pkt.size(), 0);
    chk("final_cpl_q", exp_cpl.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
